mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit address/data and 4-bit byte enable.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req_valid  input  1  CPU access request present.
REQ-005 SHALL have port: req_ready  output  1  controller idle and able to accept.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I width/sign code: [1:0] 00 byte, 01 half, 10/11 word; [2] 1 = unsigned load.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port: mem_address  output  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-011 SHALL have ports: mem_read  output  1, and mem_write  output  1  memory strobes.
REQ-012 SHALL have port: mem_byte_enable  output  4  store byte mask.
REQ-013 SHALL have port: mem_wdata  output  32  lane-aligned store data.
REQ-014 SHALL have ports: mem_rdata  input  32, and mem_resp  input  1  memory completion.
REQ-015 SHALL have ports: rsp_valid  output  1, rsp_rdata  output  32, and rsp_err  output  1  completion to CPU.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DONE; req_ready = 1 only in IDLE.
REQ-017 IDLE, req_valid=1: SHALL capture we, funct3, addr, wdata; next state ISSUE (or DONE on trap, REQ-028).
REQ-018 ISSUE SHALL assert mem_write (store) or mem_read (load), never both; outputs driven only from captured registers and stable until exit.
REQ-019 ISSUE SHALL remain until mem_resp=1 is sampled; then capture mem_rdata and go to DONE; no timeout.
REQ-020 DONE SHALL assert rsp_valid for exactly one cycle, then go to IDLE; minimum accept-to-rsp_valid latency = 2 cycles (mem_resp in first ISSUE cycle).
REQ-021 Byte enable: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads drive 4'b1111 (don't-care, fixed for determinism).
REQ-022 mem_wdata: byte wdata[7:0] shifted left 8*addr[1:0]; half wdata[15:0] shifted left 16*addr[1]; word unchanged; unused lanes zero.
REQ-023 rsp_rdata (load): selected byte/half from the same lane as REQ-021, sign-extended when funct3[2]=0, zero-extended when 1; word passes through.
REQ-024 rsp_rdata SHALL be 0 for stores; rsp_valid/rsp_rdata/rsp_err SHALL be 0 outside DONE.
REQ-025 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; handling per Configuration.
REQ-026 mem_resp outside ISSUE SHALL be ignored.

Reset
REQ-027 rst=1 at any posedge (including mid-ISSUE) SHALL force IDLE next cycle, drop the pending access, and zero mem_read, mem_write, mem_byte_enable, mem_wdata, mem_address, rsp_valid, rsp_rdata, rsp_err; req_ready = 1 after reset.

Configuration
REQ-028 With MEM_MISALIGN_TRAP_EN defined: misaligned request SHALL be accepted, skip ISSUE (no strobe), go directly to DONE with rsp_err=1, rsp_rdata=0.
REQ-029 Without MEM_MISALIGN_TRAP_EN: misaligned access SHALL be issued normally using only the bits REQ-021/022/023 consume (half ignores addr[0]; word ignores addr[1:0]); rsp_err SHALL be constant 0.

Verification
REQ-030 Store byte addr=0x1003, wdata=0x000000AB, mem_resp in 3rd ISSUE cycle -> mem_address=0x1000, be=4'b1000, mem_wdata=0xAB000000, mem_write held 3 cycles, rsp_valid 1 cycle later.
REQ-031 Load half signed addr=0x2002, mem_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; same with funct3=101 -> 0x00008001.
REQ-032 Load byte unsigned addr=0x0001, mem_rdata=0x0000F500, mem_resp same cycle ISSUE entered -> rsp_rdata=0x000000F5, rsp_valid exactly 2 cycles after acceptance.
REQ-033 rst asserted in 2nd ISSUE cycle of store, mem_resp asserted afterward -> no rsp_valid, strobes 0, req_ready=1 next cycle.
REQ-034 Word store addr=0x3002: macro on -> no mem_write, rsp_err=1 one cycle; macro off -> mem_address=0x3000, be=4'b1111, rsp_err=0.
REQ-035 Back-to-back: req_valid held high across two loads -> second accepted only in IDLE after DONE; req_ready low throughout ISSUE/DONE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding CPU load/store controller for a
// word-wide memory. Handles RV32I byte/half/word lane placement on stores
// and lane extraction with sign/zero extension on loads.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned requests complete
// immediately with rsp_err=1 instead of being issued to memory.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        trap_w;

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   byte_enable = 4'b0001 << a;
      2'b01:   byte_enable = 4'b0011 << {a[1], 1'b0};
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_align = {24'd0, wd[7:0]} << {a, 3'b000};
      2'b01:   store_align = {16'd0, wd[15:0]} << {a[1], 4'b0000};
      default: store_align = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   load_extract = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = rd;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_q;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
  endfunction

  assign trap_w = misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap_w = 1'b0;
`endif

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, wait for mem_resp in ISSUE, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = trap_w ? DONE : ISSUE;
      ISSUE:   if (mem_resp)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept and load-data capture on memory completion.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      err_q    <= trap_w;
`endif
    end else if (state_q == ISSUE && mem_resp) begin
      rdata_q  <= we_q ? 32'd0 : load_extract(funct3_q, addr_q[1:0], mem_rdata);
    end
  end

  // Outputs: memory side only in ISSUE, response side only in DONE.
  always_comb begin
    req_ready       = (state_q == IDLE);
    mem_address     = 32'd0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'd0;
    mem_wdata       = 32'd0;
    rsp_valid       = 1'b0;
    rsp_rdata       = 32'd0;
    rsp_err         = 1'b0;
    case (state_q)
      ISSUE: begin
        mem_address     = {addr_q[31:2], 2'b00};
        mem_read        = ~we_q;
        mem_write       = we_q;
        mem_byte_enable = we_q ? byte_enable(funct3_q, addr_q[1:0]) : 4'b1111;
        mem_wdata       = we_q ? store_align(funct3_q, addr_q[1:0], wdata_q) : 32'd0;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
        rsp_err   = err_q;
`endif
      end
      default: ;
    endcase
  end

endmodule
